// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator side of a byte-wide synchronous data memory.
// Converts one CPU load/store (byte, half, word; signed or unsigned loads)
// into a sequence of single-byte memory beats and returns loads assembled
// little-endian and extended to 4*DATA_WIDTH bits.
//
// Ports:
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_valid_i/req_ready_o  request handshake (one request in flight)
//   req_wen_i                1 = store, 0 = load
//   req_type_i               3'b000 BYTE, 001 HALF, 010 WORD, 100 U_BYTE, 101 U_HALF
//   req_addr_i, req_wd_i     start byte address, store data (byte 0 in LSBs)
//   resp_valid_o, resp_rd_o  completion pulse and extended load result
//   mem_a_o, mem_wd_o,
//   mem_wen_o, mem_rd_i      byte memory port; mem_rd_i is valid one cycle
//                            after the address is presented
//   misalign_o               only with MEM_MISALIGN_TRAP_EN defined: marks a
//                            response to a misaligned HALF/WORD request
//
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned accesses
// instead of performing them byte by byte.
module mem_access_ctrl #(
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned DATA_WIDTH    = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_wen_i,
  input  logic [2:0]                req_type_i,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr_i,
  input  logic [4*DATA_WIDTH-1:0]   req_wd_i,
  output logic                      resp_valid_o,
  output logic [4*DATA_WIDTH-1:0]   resp_rd_o,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                      misalign_o,
`endif
  output logic [ADDRESS_WIDTH-1:0]  mem_a_o,
  output logic [DATA_WIDTH-1:0]     mem_wd_o,
  output logic                      mem_wen_o,
  input  logic [DATA_WIDTH-1:0]     mem_rd_i
);

  localparam int unsigned CpuWidth = 4 * DATA_WIDTH;

  localparam logic [2:0] TypeByte  = 3'b000;
  localparam logic [2:0] TypeHalf  = 3'b001;
  localparam logic [2:0] TypeWord  = 3'b010;
  localparam logic [2:0] TypeUByte = 3'b100;
  localparam logic [2:0] TypeUHalf = 3'b101;

  typedef enum logic [1:0] {StIdle, StXfer, StDrain, StDone} state_e;

  state_e                     state_q, state_d;
  logic                       wen_q, wen_d;
  logic                       uns_q, uns_d;
  logic [1:0]                 last_q, last_d;   // index of the final beat (N-1)
  logic [1:0]                 k_q, k_d;
  logic [ADDRESS_WIDTH-1:0]   addr_q, addr_d;
  logic [CpuWidth-1:0]        wd_q, wd_d;
  logic [CpuWidth-1:0]        asm_q, asm_d;
  logic [CpuWidth-1:0]        rd_q, rd_d;

  // Request type decode
  logic       type_ok;
  logic [1:0] req_last;
  always_comb begin
    type_ok  = 1'b1;
    req_last = 2'd0;
    case (req_type_i)
      TypeByte, TypeUByte: req_last = 2'd0;
      TypeHalf, TypeUHalf: req_last = 2'd1;
      TypeWord:            req_last = 2'd3;
      default:             type_ok  = 1'b0;
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;
  logic req_misaligned;
  assign req_misaligned = type_ok &&
                          (((req_last == 2'd1) && req_addr_i[0]) ||
                           ((req_last == 2'd3) && (req_addr_i[1:0] != 2'b00)));
  assign misalign_o = (state_q == StDone) && misalign_q;
`endif

  always_comb begin
    state_d      = state_q;
    wen_d        = wen_q;
    uns_d        = uns_q;
    last_d       = last_q;
    k_d          = k_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    asm_d        = asm_q;
    rd_d         = rd_q;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    mem_a_o      = '0;
    mem_wd_o     = '0;
    mem_wen_o    = 1'b0;

    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          wen_d  = req_wen_i;
          uns_d  = req_type_i[2];
          last_d = req_last;
          addr_d = req_addr_i;
          wd_d   = req_wd_i;
          k_d    = 2'd0;
          asm_d  = '0;
`ifdef MEM_MISALIGN_TRAP_EN
          misalign_d = 1'b0;
          if (!type_ok || req_misaligned) begin
            misalign_d = req_misaligned;
            rd_d       = '0;
            state_d    = StDone;
          end else begin
            state_d = StXfer;
          end
`else
          if (!type_ok) begin
            rd_d    = '0;
            state_d = StDone;
          end else begin
            state_d = StXfer;
          end
`endif
        end
      end

      StXfer: begin
        mem_a_o = addr_q + ADDRESS_WIDTH'(k_q);
        if (wen_q) begin
          mem_wen_o = 1'b1;
          mem_wd_o  = wd_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
        end else if (k_q != 2'd0) begin
          // Registered read data belongs to the previous beat
          asm_d[int'(k_q - 2'd1)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_i;
        end
        if (k_q == last_q) begin
          if (wen_q) begin
            rd_d    = '0;
            state_d = StDone;
          end else begin
            state_d = StDrain;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      StDrain: begin
        asm_d[int'(last_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rd_i;
        case (last_q)
          2'd0: rd_d = {{(CpuWidth-DATA_WIDTH){~uns_q & asm_d[DATA_WIDTH-1]}},
                        asm_d[DATA_WIDTH-1:0]};
          2'd1: rd_d = {{(CpuWidth-2*DATA_WIDTH){~uns_q & asm_d[2*DATA_WIDTH-1]}},
                        asm_d[2*DATA_WIDTH-1:0]};
          default: rd_d = asm_d;
        endcase
        state_d = StDone;
      end

      StDone: begin
        resp_valid_o = 1'b1;
        state_d      = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  assign resp_rd_o = rd_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      last_q     <= 2'd0;
      k_q        <= 2'd0;
      addr_q     <= '0;
      wd_q       <= '0;
      asm_q      <= '0;
      rd_q       <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      uns_q      <= uns_d;
      last_q     <= last_d;
      k_q        <= k_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      asm_q      <= asm_d;
      rd_q       <= rd_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a byte-wide synchronous memory model.
module tb_mem_access_ctrl;

  localparam logic [2:0] TByte  = 3'b000;
  localparam logic [2:0] THalf  = 3'b001;
  localparam logic [2:0] TWord  = 3'b010;
  localparam logic [2:0] TUByte = 3'b100;
  localparam logic [2:0] TUHalf = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_wen;
  logic [2:0]  req_type;
  logic [7:0]  req_addr;
  logic [31:0] req_wd;
  logic        resp_valid;
  logic [31:0] resp_rd;
  logic [7:0]  mem_a, mem_wd, mem_rd;
  logic        mem_wen;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDRESS_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_wen_i    (req_wen),
    .req_type_i   (req_type),
    .req_addr_i   (req_addr),
    .req_wd_i     (req_wd),
    .resp_valid_o (resp_valid),
    .resp_rd_o    (resp_rd),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o   (misalign),
`endif
    .mem_a_o      (mem_a),
    .mem_wd_o     (mem_wd),
    .mem_wen_o    (mem_wen),
    .mem_rd_i     (mem_rd)
  );

`ifndef MEM_MISALIGN_TRAP_EN
  assign misalign = 1'b0;
`endif

  // Memory model; bench preloads go through the same process.
  logic [7:0] mem [0:255];
  logic       pre_we = 1'b0;
  logic [7:0] pre_a = 8'h00, pre_d = 8'h00;
  always @(posedge clk) begin
    mem_rd <= mem[mem_a];
    if (pre_we) mem[pre_a] <= pre_d;
    else if (mem_wen) mem[mem_a] <= mem_wd;
  end

  // Per-request observation record
  int          lat, wen_cnt, busy_ready;
  logic        issue_ready;
  logic [31:0] rd_res;
  logic        mis_res;
  logic [7:0]  a_log [0:15];
  logic [7:0]  wd_log [0:15];
  logic        wen_log [0:15];

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request and log every cycle until the response (bounded).
  task automatic do_req(input logic wen, input logic [2:0] typ, input logic [7:0] addr,
                        input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_type = typ; req_addr = addr; req_wd = wd;
    issue_ready = req_ready;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; wen_cnt = 0; busy_ready = 0; rd_res = 32'hx; mis_res = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      a_log[c] = mem_a; wd_log[c] = mem_wd; wen_log[c] = mem_wen;
      if (mem_wen) wen_cnt++;
      if (req_ready) busy_ready++;
      if (resp_valid) begin
        lat = c; rd_res = resp_rd; mis_res = misalign;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_type = TByte;
    req_addr = 8'h00; req_wd = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_rd !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=0", resp_rd); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got=%b exp=0", mem_wen); end
    checks++; if (mem_a !== 8'h00) begin errors++; $display("FAIL reset_a got=%h exp=00", mem_a); end
    checks++; if (mem_wd !== 8'h00) begin errors++; $display("FAIL reset_wd got=%h exp=00", mem_wd); end
    rst_n = 1'b1;
  endtask

  task automatic test_word_store;
    logic [7:0] exp_wd [0:3];
    exp_wd[0] = 8'hEF; exp_wd[1] = 8'hBE; exp_wd[2] = 8'hAD; exp_wd[3] = 8'hDE;
    do_req(1'b1, TWord, 8'h10, 32'hDEADBEEF);
    checks++; if (lat != 5) begin errors++; $display("FAIL st_word_lat got=%0d exp=5", lat); end
    checks++; if (busy_ready != 0) begin errors++; $display("FAIL st_word_ready_busy got=%0d exp=0", busy_ready); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (a_log[i+1] !== 8'h10 + 8'(i) || wd_log[i+1] !== exp_wd[i] || wen_log[i+1] !== 1'b1) begin
        errors++;
        $display("FAIL st_word_beat%0d got a=%h wd=%h wen=%b exp a=%h wd=%h wen=1",
                 i, a_log[i+1], wd_log[i+1], wen_log[i+1], 8'h10 + 8'(i), exp_wd[i]);
      end
    end
    checks++; if (wen_log[5] !== 1'b0) begin errors++; $display("FAIL st_word_done_wen got=%b exp=0", wen_log[5]); end
    checks++; if (rd_res !== 32'h0) begin errors++; $display("FAIL st_word_rd got=%h exp=0", rd_res); end
  endtask

  task automatic test_word_load;
    do_req(1'b0, TWord, 8'h10, 32'h0);
    checks++; if (lat != 6) begin errors++; $display("FAIL ld_word_lat got=%0d exp=6", lat); end
    checks++; if (rd_res !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_word_rd got=%h exp=deadbeef", rd_res); end
    checks++; if (wen_cnt != 0) begin errors++; $display("FAIL ld_word_wen got=%0d exp=0", wen_cnt); end
  endtask

  task automatic test_sign_ext;
    preload(8'h20, 8'h80);
    preload(8'h21, 8'h34);
    preload(8'h22, 8'h92);
    do_req(1'b0, TByte, 8'h20, 32'h0);
    checks++; if (lat != 3) begin errors++; $display("FAIL ld_byte_lat got=%0d exp=3", lat); end
    checks++; if (rd_res !== 32'hFFFFFF80) begin errors++; $display("FAIL ld_byte_rd got=%h exp=ffffff80", rd_res); end
    do_req(1'b0, TUByte, 8'h20, 32'h0);
    checks++; if (rd_res !== 32'h00000080) begin errors++; $display("FAIL ld_ubyte_rd got=%h exp=00000080", rd_res); end
    do_req(1'b0, THalf, 8'h21, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (lat != 1 || rd_res !== 32'h0 || mis_res !== 1'b1) begin
      errors++; $display("FAIL ld_half_trap got lat=%0d rd=%h mis=%b exp lat=1 rd=0 mis=1", lat, rd_res, mis_res);
    end
`else
    checks++; if (lat != 4) begin errors++; $display("FAIL ld_half_lat got=%0d exp=4", lat); end
    checks++; if (rd_res !== 32'hFFFF9234) begin errors++; $display("FAIL ld_half_rd got=%h exp=ffff9234", rd_res); end
    do_req(1'b0, TUHalf, 8'h21, 32'h0);
    checks++; if (rd_res !== 32'h00009234) begin errors++; $display("FAIL ld_uhalf_rd got=%h exp=00009234", rd_res); end
`endif
  endtask

  task automatic test_wrap;
    do_req(1'b1, TWord, 8'hFE, 32'h11223344);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (lat != 1 || wen_cnt != 0 || mis_res !== 1'b1) begin
      errors++; $display("FAIL wrap_st_trap got lat=%0d wen=%0d mis=%b exp lat=1 wen=0 mis=1", lat, wen_cnt, mis_res);
    end
`else
    checks++; if (lat != 5) begin errors++; $display("FAIL wrap_st_lat got=%0d exp=5", lat); end
    checks++; if (a_log[1] !== 8'hFE || a_log[2] !== 8'hFF || a_log[3] !== 8'h00 || a_log[4] !== 8'h01) begin
      errors++; $display("FAIL wrap_st_addr got=%h,%h,%h,%h exp=fe,ff,00,01", a_log[1], a_log[2], a_log[3], a_log[4]);
    end
    checks++; if (mem[8'hFE] !== 8'h44 || mem[8'hFF] !== 8'h33 || mem[8'h00] !== 8'h22 || mem[8'h01] !== 8'h11) begin
      errors++; $display("FAIL wrap_st_mem got=%h,%h,%h,%h exp=44,33,22,11", mem[8'hFE], mem[8'hFF], mem[8'h00], mem[8'h01]);
    end
    do_req(1'b0, TWord, 8'hFE, 32'h0);
    checks++; if (rd_res !== 32'h11223344) begin errors++; $display("FAIL wrap_ld_rd got=%h exp=11223344", rd_res); end
`endif
  endtask

  task automatic test_reset_mid;
    int seen;
    preload(8'h40, 8'h00); preload(8'h41, 8'h00);
    preload(8'h42, 8'h00); preload(8'h43, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_type = TWord; req_addr = 8'h40; req_wd = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (mem_a !== 8'h41 || mem_wen !== 1'b1) begin
      errors++; $display("FAIL rstmid_beat got a=%h wen=%b exp a=41 wen=1", mem_a, mem_wen);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (mem_wen !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_quiet got wen=%b valid=%b exp 0,0", mem_wen, resp_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", req_ready); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid || mem_wen) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_activity got=%0d exp=0", seen); end
    checks++; if (mem[8'h40] !== 8'hD4 || mem[8'h41] !== 8'hC3 || mem[8'h42] !== 8'h00 || mem[8'h43] !== 8'h00) begin
      errors++; $display("FAIL rstmid_mem got=%h,%h,%h,%h exp=d4,c3,00,00", mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]);
    end
    do_req(1'b0, TByte, 8'h40, 32'h0);
    checks++; if (lat != 3 || rd_res !== 32'hFFFFFFD4) begin
      errors++; $display("FAIL rstmid_load got lat=%0d rd=%h exp lat=3 rd=ffffffd4", lat, rd_res);
    end
  endtask

  task automatic test_misalign;
    do_req(1'b0, TWord, 8'h03, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (lat != 1 || wen_cnt != 0) begin
      errors++; $display("FAIL mis_word_lat got lat=%0d wen=%0d exp lat=1 wen=0", lat, wen_cnt);
    end
    checks++; if (rd_res !== 32'h0 || mis_res !== 1'b1) begin
      errors++; $display("FAIL mis_word_resp got rd=%h mis=%b exp rd=0 mis=1", rd_res, mis_res);
    end
    do_req(1'b0, TByte, 8'h20, 32'h0);
    checks++; if (mis_res !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", mis_res); end
`else
    checks++; if (lat != 6 || wen_cnt != 0 || a_log[1] !== 8'h03 || a_log[4] !== 8'h06) begin
      errors++; $display("FAIL mis_word_bytewise got lat=%0d wen=%0d a1=%h a4=%h exp lat=6 wen=0 a1=03 a4=06",
                         lat, wen_cnt, a_log[1], a_log[4]);
    end
`endif
  endtask

  task automatic test_invalid_type;
    do_req(1'b0, 3'b011, 8'h20, 32'h0);
    checks++; if (lat != 1 || rd_res !== 32'h0 || wen_cnt != 0) begin
      errors++; $display("FAIL inval_load got lat=%0d rd=%h wen=%0d exp lat=1 rd=0 wen=0", lat, rd_res, wen_cnt);
    end
    do_req(1'b1, 3'b111, 8'h20, 32'hFFFFFFFF);
    checks++; if (lat != 1 || wen_cnt != 0 || mem[8'h20] !== 8'h80) begin
      errors++; $display("FAIL inval_store got lat=%0d wen=%0d mem=%h exp lat=1 wen=0 mem=80", lat, wen_cnt, mem[8'h20]);
    end
  endtask

  task automatic test_back_to_back;
    do_req(1'b1, TByte, 8'h30, 32'h0000005A);
    checks++; if (lat != 2) begin errors++; $display("FAIL b2b_st_byte_lat got=%0d exp=2", lat); end
    do_req(1'b0, TUByte, 8'h30, 32'h0);
    checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", issue_ready); end
    checks++; if (lat != 3 || rd_res !== 32'h0000005A) begin
      errors++; $display("FAIL b2b_ld got lat=%0d rd=%h exp lat=3 rd=0000005a", lat, rd_res);
    end
    do_req(1'b1, TUHalf, 8'h30, 32'h1234C0DE);
    checks++; if (lat != 3 || wen_cnt != 2) begin
      errors++; $display("FAIL b2b_st_uhalf got lat=%0d wen=%0d exp lat=3 wen=2", lat, wen_cnt);
    end
    do_req(1'b0, THalf, 8'h30, 32'h0);
    checks++; if (rd_res !== 32'hFFFFC0DE) begin errors++; $display("FAIL b2b_ld_half got=%h exp=ffffc0de", rd_res); end
    checks++; if (mem[8'h32] === 8'h34) begin errors++; $display("FAIL b2b_st_overrun got=%h exp!=34", mem[8'h32]); end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_word_load();
    test_sign_ext();
    test_wrap();
    test_reset_mid();
    test_misalign();
    test_invalid_type();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
